// File: rtl/fpcvt_pkg.sv
// ============================================================================
// fpcvt_pkg : shared widths, FSM state and result types for fpcvt_round
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpcvt_pkg;

  localparam int MAG_W   = 11;
  localparam int EXP_W   = 3;
  localparam int SIG_W   = 4;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [SIG_W-1:0] SIG_MAX    = {SIG_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_RENORM = {1'b1, {(SIG_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fpcvt_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fpcvt_res_t;

endpackage

`default_nettype wire

// File: rtl/fpcvt_round_inc.sv
// ============================================================================
// fpcvt_round_inc : combinational round-half-up of {f, rbit, exp} -> {sig, exp}
// Build option    : FPCVT_ROUND_EN selects rounding; otherwise truncation.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpcvt_round_inc
  import fpcvt_pkg::*;
(
  input  logic [SIG_W-1:0] f,
  input  logic             rbit,
  input  logic [EXP_W-1:0] exp_in,
  output logic [SIG_W-1:0] sig,
  output logic [EXP_W-1:0] exp_out
);

`ifdef FPCVT_ROUND_EN
  always_comb begin
    sig     = f;
    exp_out = exp_in;
    if (rbit) begin
      if (f != SIG_MAX) begin
        sig = f + SIG_W'(1);
      end else if (exp_in != EXP_W'(EXP_MAX)) begin
        // 1111 + 1 carries out: renormalise to 1000 one exponent higher
        sig     = SIG_RENORM;
        exp_out = exp_in + EXP_W'(1);
      end
      // f == max at max exponent keeps {max, max}: saturation
    end
  end
`else
  logic unused_rbit;
  assign unused_rbit = rbit;
  assign sig         = f;
  assign exp_out     = exp_in;
`endif

endmodule

`default_nettype wire

// File: rtl/fpcvt_round.sv
// ============================================================================
// fpcvt_round : serial right-shift of the magnitude by E, then round to SIG_W
// Build option: FPCVT_ROUND_EN enables round-half-up (default: truncate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpcvt_round
  import fpcvt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig
);

  fpcvt_state_t     r_state;
  logic [MAG_W-1:0] r_sh;
  logic [EXP_W-1:0] r_cnt;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic             r_rbit;
  fpcvt_res_t       r_res;

  logic [SIG_W-1:0] w_sig;
  logic [EXP_W-1:0] w_exp;

  fpcvt_round_inc u_inc (
    .f       (r_sh[SIG_W-1:0]),
    .rbit    (r_rbit),
    .exp_in  (r_exp),
    .sig     (w_sig),
    .exp_out (w_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_rbit    <= 1'b0;
      r_res     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_sh     <= in_mag;
            r_cnt    <= in_exp;
            r_exp    <= in_exp;
            r_sign   <= in_sign;
            r_rbit   <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= (in_exp != '0) ? SHIFT : ROUND;
          end
        end
        SHIFT: begin
          // the last bit shifted out becomes the round bit
          r_rbit <= r_sh[0];
          r_sh   <= r_sh >> 1;
          r_cnt  <= r_cnt - EXP_W'(1);
          if (r_cnt == EXP_W'(1)) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_res.sign <= r_sign;
          r_res.exp  <= w_exp;
          r_res.sig  <= w_sig;
          out_valid  <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign out_sign = r_res.sign;
  assign out_exp  = r_res.exp;
  assign out_sig  = r_res.sig;

endmodule

`default_nettype wire

// File: doc/fpcvt_round.md
Name: fpcvt_round

Overview:
- Downstream stage of the exponent (leading-zero) stage in the Lab2 sign-magnitude to floating-point converter.
- Consumes sign, 11-bit magnitude and 3-bit exponent E.
- Serially shifts the magnitude right by E bits, one bit per clock, to extract the 4-bit significand F, then rounds using the last bit shifted out.
- Presents {S, E, F} on a valid/ready output handshake, so the value is F * 2^E with sign S.

Parameters:
MAG_W, 11, magnitude width; only the default is supported and verified.
EXP_W, 3, exponent width; max exponent is 2^EXP_W-1 = 7.
SIG_W, 4, significand width.

Ports:
clk        in   1      rising-edge clock
rst        in   1      synchronous, active-high reset
in_valid   in   1      input beat valid
in_ready   out  1      block can accept a beat
in_sign    in   1      sign bit, passed through unchanged
in_mag     in   MAG_W  unsigned magnitude
in_exp     in   EXP_W  exponent from the upstream exponent stage
out_valid  out  1      result valid
out_ready  in   1      consumer accepts result
out_sign   out  1      S
out_exp    out  EXP_W  E after rounding
out_sig    out  SIG_W  F after rounding

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; all state is updated on the clk rising edge.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_exp=0, out_sig=0, and internal shift register, counter and round bit are 0.
- Reset asserted mid-operation abandons the beat in flight. Next cycle is IDLE with no output produced.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: in_ready=1.
  - in_valid&&in_ready captures sign, mag into shift register sh, exp into cnt and exp_r, and clears rbit.
  - Next state is SHIFT if exp!=0, else ROUND.
- SHIFT: in_ready=0. Each cycle: rbit<=sh[0], sh<=sh>>1, cnt<=cnt-1. When cnt==1 the next state is ROUND. Exactly E shift cycles occur.
- ROUND: in_ready=0. Let f=sh[3:0].
  - rbit=0: F=f, E=exp_r.
  - rbit=1 and f!=15: F=f+1, E=exp_r.
  - rbit=1, f==15, exp_r<7: F=8 (4'b1000), E=exp_r+1.
  - rbit=1, f==15, exp_r==7: saturate, F=15, E=7.
  - Registers the result into out_*, then goes to DONE.
- DONE: out_valid=1 and out_* are held stable.
  - out_ready=1 returns to IDLE, with out_valid=0 the next cycle.
  - out_ready=0 stays in DONE indefinitely.
  - A new input is never accepted in the same cycle as output handoff, because in_ready=0 in DONE.
- Latency: the accept edge counts as edge 1; out_valid rises after edge E+2.
  - Throughput is one beat per E+3 cycles minimum.
- out_* retain their last value after handoff until the next ROUND.
- in_exp inconsistent with in_mag is not checked. The result is computed from the supplied exponent exactly as above.
- mag=0, E=0 yields F=0, E=0.

Optional Feature:
- Macro: FPCVT_ROUND_EN.
- Defined: round-half-up as specified in ROUND above.
- Undefined: truncation. F=sh[3:0] and E=exp_r always. rbit is not used, and the overflow and saturation logic is not compiled in.
- Latency is identical in both builds.

Decomposition:
- Package fpcvt_pkg holds:
  - MAG_W, EXP_W, SIG_W and EXP_MAX=7.
  - State enum fpcvt_state_t {IDLE, SHIFT, ROUND, DONE}.
  - Result struct fpcvt_res_t {sign, exp, sig}.
- One sub-module, fpcvt_round_inc: combinational {f, rbit, exp} -> {F, E}.
  - Contains the increment, overflow renormalise and saturate logic; it is the only part gated by FPCVT_ROUND_EN.
- The FSM, shift register and counter stay in fpcvt_round.

Test Plan:
1. sign=1, mag=422, exp=5 -> after 7 edges out_valid=1, S=1, E=5, F=13 (rbit=0); with out_ready=1, out_valid drops next cycle.
2. mag=252, exp=4 -> with FPCVT_ROUND_EN: E=5, F=8 (renormalised 15+1); without it: E=4, F=15; out_valid after 6 edges in both builds.
3. mag=2047, exp=7 -> with FPCVT_ROUND_EN: saturates to E=7, F=15. mag=9, exp=0 -> E=0, F=9, out_valid after 2 edges. mag=0, exp=0 -> E=0, F=0.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_* stay stable, in_ready=0, and in_valid pulses are ignored; raise out_ready -> IDLE; next beat is accepted.
5. Assert rst during SHIFT, with mag=2047, exp=7 accepted 3 edges earlier -> next cycle IDLE, in_ready=1, out_valid=0, all out_* =0, and no result is ever emitted for that beat.
6. Back-to-back in_valid=1 with out_ready=1 tied high, exps 0,3,7 -> each result is correct; beat spacing is E+3 cycles; no beat is dropped or duplicated.
